// File: rtl/mandel_iter_core.sv
// Fixed-point Mandelbrot iteration engine: z <- z^2 + c from z = 0 until the
// magnitude reaches 4.0, the next z overflows the W-bit format, or the
// sampled iteration limit is hit. One point in flight at a time.
module mandel_iter_core #(
    parameter int INT_BITS  = 2,
    parameter int FRAC_BITS = 12,
    parameter int ITER_BITS = 8,
    parameter int W         = INT_BITS + FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         cx,
    input  logic [W-1:0]         cy,
    input  logic [ITER_BITS-1:0] max_iter,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ITER_BITS-1:0] iter_count,
    output logic                 escaped
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // |z|^2 escape threshold, 4.0 in the fixed-point format
    localparam logic [W+1:0] ESC_LIM = (W+2)'(1) << (FRAC_BITS + 2);

    state_t                 state_q, state_d;
    logic signed [W-1:0]    x_q, x_d, y_q, y_d;
    logic signed [W-1:0]    cx_q, cx_d, cy_q, cy_d;
    logic [ITER_BITS-1:0]   it_q, it_d, mi_q, mi_d;
    logic [ITER_BITS-1:0]   cnt_q, cnt_d;
    logic                   esc_q, esc_d;

    // Full-width products; shifts floor toward -inf
    logic signed [2*W-1:0]  p_xx, p_yy, p_xy;
    logic signed [2*W-1:0]  sq_x, sq_y, xy2;
    logic [W+1:0]           mag;
    logic signed [W+2:0]    nx, ny;
    logic                   ovf;
    logic                   unused_bits;

    assign p_xx = x_q * x_q;
    assign p_yy = y_q * y_q;
    assign p_xy = x_q * y_q;
    assign sq_x = p_xx >>> FRAC_BITS;
    assign sq_y = p_yy >>> FRAC_BITS;
    assign xy2  = p_xy >>> (FRAC_BITS - 1);

    assign mag = sq_x[W+1:0] + sq_y[W+1:0];
    assign nx  = sq_x[W+2:0] - sq_y[W+2:0] + {{3{cx_q[W-1]}}, cx_q};
    assign ny  = xy2[W+2:0] + {{3{cy_q[W-1]}}, cy_q};

    // Next z is unrepresentable when the bits above the W-bit sign differ
    assign ovf = ((nx[W+2:W-1] != '0) && (nx[W+2:W-1] != '1)) ||
                 ((ny[W+2:W-1] != '0) && (ny[W+2:W-1] != '1));

    // High product bits beyond the W+3-bit working range are intentionally dropped
    assign unused_bits = ^{sq_x, sq_y, xy2};

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign iter_count = cnt_q;
    assign escaped    = esc_q;

    // State and datapath registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            it_q    <= '0;
            mi_q    <= '0;
            cnt_q   <= '0;
            esc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            it_q    <= it_d;
            mi_q    <= mi_d;
            cnt_q   <= cnt_d;
            esc_q   <= esc_d;
        end
    end

    // Next-state: accept, iterate with escape/limit/overflow priority, hold result
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        it_d    = it_q;
        mi_d    = mi_q;
        cnt_d   = cnt_q;
        esc_d   = esc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    mi_d    = max_iter;
                    x_d     = '0;
                    y_d     = '0;
                    it_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mag >= ESC_LIM) begin
                    state_d = DONE;
                    esc_d   = 1'b1;
                    cnt_d   = it_q;
                end else if (it_q == mi_q) begin
                    state_d = DONE;
                    esc_d   = 1'b0;
                    cnt_d   = it_q;
                end else if (ovf) begin
                    // it_q < mi_q here, so the increment cannot wrap
                    state_d = DONE;
                    esc_d   = 1'b1;
                    cnt_d   = it_q + ITER_BITS'(1);
                end else begin
                    x_d  = nx[W-1:0];
                    y_d  = ny[W-1:0];
                    it_d = it_q + ITER_BITS'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mandel_iter_core.sv
// Bench for mandel_iter_core: directed points with hand-derived results,
// backpressure, reset during RUN, and random points against a numeric model.
module tb_mandel_iter_core;

    localparam int INT_BITS  = 2;
    localparam int FRAC_BITS = 12;
    localparam int ITER_BITS = 8;
    localparam int W         = INT_BITS + FRAC_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [W-1:0]         cx = '0;
    logic [W-1:0]         cy = '0;
    logic [ITER_BITS-1:0] max_iter = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [ITER_BITS-1:0] iter_count;
    logic                 escaped;

    int vectors = 0;
    int miscompares = 0;

    mandel_iter_core #(
        .INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS), .ITER_BITS(ITER_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .cx(cx), .cy(cy), .max_iter(max_iter),
        .out_valid(out_valid), .out_ready(out_ready),
        .iter_count(iter_count), .escaped(escaped)
    );

    always #5 clk = ~clk;

    // Reference: iterate the recurrence on plain integers (value * 2^FRAC_BITS)
    task automatic model(input logic signed [W-1:0] pcx, input logic signed [W-1:0] pcy,
                         input int mi, output int cnt, output bit esc, output int k);
        longint x = 0, y = 0, c_r, c_i, sqx, sqy, xy2, nx, ny;
        longint lim = longint'(1) << (W - 1);
        int it = 0;
        c_r = pcx;
        c_i = pcy;
        forever begin
            sqx = (x * x) >>> FRAC_BITS;
            sqy = (y * y) >>> FRAC_BITS;
            xy2 = (x * y) >>> (FRAC_BITS - 1);
            nx  = sqx - sqy + c_r;
            ny  = xy2 + c_i;
            k = it + 1;
            if (sqx + sqy >= (longint'(4) << FRAC_BITS)) begin
                esc = 1; cnt = it; return;
            end
            if (it == mi) begin
                esc = 0; cnt = it; return;
            end
            if (nx < -lim || nx >= lim || ny < -lim || ny >= lim) begin
                esc = 1; cnt = it + 1; return;
            end
            x = nx;
            y = ny;
            it++;
        end
    endtask

    // Drive one point, count RUN cycles to out_valid, stall, then handshake.
    task automatic run_point(input logic [W-1:0] pcx, input logic [W-1:0] pcy,
                             input logic [ITER_BITS-1:0] pmi, input int stall,
                             output int k, output logic [ITER_BITS-1:0] cnt,
                             output logic esc, output bit tmo, output bit rdy_hi);
        int cyc = 0;
        tmo = 0; rdy_hi = 0; k = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!in_ready) tmo = 1;
        cx = pcx; cy = pcy; max_iter = pmi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cx = W'($urandom); cy = W'($urandom); max_iter = ITER_BITS'($urandom);
        while (!out_valid && k < 600) begin
            if (in_ready) rdy_hi = 1;
            @(posedge clk); #1; k++;
        end
        if (!out_valid) tmo = 1;
        cnt = iter_count;
        esc = escaped;
        repeat (stall) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || iter_count !== '0 || escaped !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b iter_count=%0d escaped=%b, want 1 0 0 0",
                     in_ready, out_valid, iter_count, escaped);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] tcx [4] = '{14'h0000, 14'h1000, 14'h2000, 14'h3000};
        int tmi [4] = '{10, 255, 255, 255};
        int tcnt[4] = '{10, 2, 1, 255};
        bit tesc[4] = '{0, 1, 1, 0};
        int tk  [4] = '{11, 2, 2, 256};
        int k; logic [ITER_BITS-1:0] cnt; logic esc; bit tmo, rdy;
        for (int i = 0; i < 4; i++) begin
            run_point(tcx[i], '0, ITER_BITS'(tmi[i]), 0, k, cnt, esc, tmo, rdy);
            vectors++;
            if (tmo || cnt !== ITER_BITS'(tcnt[i]) || esc !== tesc[i]) begin
                miscompares++;
                $display("FAIL directed%0d result: iter_count=%0d escaped=%b timeout=%0d, want %0d %0d",
                         i, cnt, esc, tmo, tcnt[i], tesc[i]);
            end
            vectors++;
            if (k != tk[i] || rdy) begin
                miscompares++;
                $display("FAIL directed%0d latency: cycles=%0d in_ready_seen=%0d, want %0d 0",
                         i, k, rdy, tk[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int k, cyc; logic [ITER_BITS-1:0] cnt; logic esc; bit tmo, rdy;
        cx = 14'h1000; cy = '0; max_iter = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; cx = W'($urandom); max_iter = 8'd0;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || iter_count !== 8'd2 || escaped !== 1'b1) begin
                miscompares++;
                $display("FAIL stall%0d: out_valid=%b in_ready=%b iter_count=%0d escaped=%b, want 1 0 2 1",
                         i, out_valid, in_ready, iter_count, escaped);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        run_point(14'h2000, '0, 8'd255, 1, k, cnt, esc, tmo, rdy);
        vectors++;
        if (tmo || cnt !== 8'd1 || esc !== 1'b1 || k != 2) begin
            miscompares++;
            $display("FAIL after_release: iter_count=%0d escaped=%b cycles=%0d, want 1 1 2",
                     cnt, esc, k);
        end
    endtask

    task automatic test_reset_mid_run();
        int k; logic [ITER_BITS-1:0] cnt; logic esc; bit tmo, rdy;
        cx = 14'h3000; cy = '0; max_iter = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || iter_count !== '0 || escaped !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b iter_count=%0d escaped=%b, want 0 1 0 0",
                     out_valid, in_ready, iter_count, escaped);
        end
        run_point('0, '0, 8'd0, 0, k, cnt, esc, tmo, rdy);
        vectors++;
        if (tmo || cnt !== 8'd0 || esc !== 1'b0 || k != 1) begin
            miscompares++;
            $display("FAIL max_iter0: iter_count=%0d escaped=%b cycles=%0d, want 0 0 1", cnt, esc, k);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] rcx, rcy; int rmi, ecnt, ek, k; bit eesc, tmo, rdy;
        logic [ITER_BITS-1:0] cnt; logic esc;
        for (int n = 0; n < 40; n++) begin
            rcx = W'($urandom);
            rcy = (n < 10) ? '0 : W'($urandom);
            rmi = (n % 8 == 0) ? 255 : int'($urandom_range(0, 30));
            model(rcx, rcy, rmi, ecnt, eesc, ek);
            run_point(rcx, rcy, ITER_BITS'(rmi), int'($urandom_range(0, 3)), k, cnt, esc, tmo, rdy);
            vectors++;
            if (tmo || cnt !== ITER_BITS'(ecnt) || esc !== eesc || k != ek || rdy) begin
                miscompares++;
                $display("FAIL random%0d c=(%h,%h) max=%0d: iter_count=%0d escaped=%b cycles=%0d rdy=%0d, want %0d %0d %0d 0",
                         n, rcx, rcy, rmi, cnt, esc, k, rdy, ecnt, eesc, ek);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
